// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with decode, a registered result/zero/ctrl and valid/ready handshakes.
// Defining ALU_MUL_EN adds a radix-2 shift-add multiplier that holds the unit busy for XLEN cycles.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            opb5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl
);
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            zero;
    logic [3:0]      ctrl;
  } rsp_t;

  logic [3:0]         op;
  logic [XLEN-1:0]    alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic               accept, drain, is_mul, load_alu;
  logic               fsm_idle, mul_done;
  logic [XLEN-1:0]    mul_res;
  rsp_t               rsp_q, rsp_d;
  logic               vld_q;

  // Decode
  always_comb begin
    op = OP_ADD;
    case (ALUOp)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_PASSB;
      default: begin
        case (funct3)
          3'b000:  op = (opb5 & funct7b5) ? OP_SUB : OP_ADD;
          3'b001:  op = OP_SLL;
          3'b010:  op = OP_SLT;
          3'b011:  op = OP_SLTU;
          3'b100:  op = OP_XOR;
          3'b101:  op = funct7b5 ? OP_SRA : OP_SRL;
          3'b110:  op = OP_OR;
          default: op = OP_AND;
        endcase
`ifdef ALU_MUL_EN
        if (opb5 & funct7b0 & (funct3 == 3'b000)) op = OP_MUL;
`endif
      end
    endcase
  end

  // Single-cycle datapath
  assign shamt = src_b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = src_a + src_b;
      OP_SUB:   alu_res = src_a - src_b;
      OP_AND:   alu_res = src_a & src_b;
      OP_OR:    alu_res = src_a | src_b;
      OP_XOR:   alu_res = src_a ^ src_b;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_SLL:   alu_res = src_a << shamt;
      OP_SRL:   alu_res = src_a >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(src_a) >>> shamt);
      OP_PASSB: alu_res = src_b;
      default:  alu_res = '0;
    endcase
  end

  // Handshake; in_ready is forced low while reset is held
  assign in_ready = rst_n & fsm_idle & (~vld_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = vld_q & out_ready;
  assign is_mul   = (op == OP_MUL);
  assign load_alu = accept & ~is_mul;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    mcand_q, mplier_q, prod_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               mul_start, mul_last;

  assign mul_start = accept & is_mul;
  // The final iteration is folded into the result load, so XLEN-1 is the last count
  assign mul_last  = (cnt_q == SHAMT_W'(XLEN-1));
  assign mul_res   = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mul_start) state_d = S_MUL;
      S_MUL:   if (mul_last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fsm_idle = (state_q == S_IDLE);
    mul_done = (state_q == S_MUL) & mul_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (mul_start) begin
      mcand_q  <= src_a;
      mplier_q <= src_b;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (state_q == S_MUL) begin
      prod_q   <= mul_res;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_f7b0;
  assign unused_f7b0 = funct7b0;
  assign fsm_idle    = 1'b1;
  assign mul_done    = 1'b0;
  assign mul_res     = '0;
`endif

  // Output register; mul_done and an accept can never coincide since the unit is busy in MUL
  always_comb begin
    rsp_d = rsp_q;
    if (mul_done)      rsp_d = '{data: mul_res, zero: (mul_res == '0), ctrl: OP_MUL};
    else if (load_alu) rsp_d = '{data: alu_res, zero: (alu_res == '0), ctrl: op};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
      vld_q <= 1'b0;
    end else begin
      rsp_q <= rsp_d;
      if (mul_done | load_alu) vld_q <= 1'b1;
      else if (drain)          vld_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign result    = rsp_q.data;
  assign zero      = rsp_q.zero;
  assign alu_ctrl  = rsp_q.ctrl;
endmodule
